// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchronizer, start validation, 3-sample majority per bit.
// Completed frames report as one-cycle valid/framing/parity pulses; rx_data_out holds the last frame.
module uart_rx_os #(
  parameter int CLK_DIV      = 4,
  parameter int OVERSAMPLING = 8,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 sysclk_in,
  input  logic                 nrst_in,
  input  logic                 rx_serial_in,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_valid_out,
  output logic                 rx_busy_out,
  output logic                 rx_frame_err_out,
  output logic                 rx_parity_err_out
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLING);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int OS_H  = OVERSAMPLING / 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 rxs_q, rxs_d;
  logic                 rxs_dly_q, rxs_dly_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [OS_W-1:0]      s_q, s_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_pls_q, perr_pls_d;

  logic            tick, wrap, decide, maj;
  logic [OS_W-1:0] s_nxt;

  always_comb begin
    state_d    = state_q;
    sync1_d    = rx_serial_in;
    rxs_d      = sync1_q;
    rxs_dly_d  = rxs_q;
    div_d      = div_q;
    s_d        = s_q;
    bit_d      = bit_q;
    smp_d      = smp_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    perr_pls_d = 1'b0;

    // Sample points are named by the index value the tick moves s to.
    tick   = (div_q == DIV_W'(CLK_DIV - 1));
    s_nxt  = (s_q == OS_W'(OVERSAMPLING - 1)) ? '0 : s_q + 1'b1;
    wrap   = tick && (s_q == OS_W'(OVERSAMPLING - 1));
    decide = tick && (s_nxt == OS_W'(OS_H + 1));
    maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);

    if (state_q != S_IDLE && state_q != S_BREAK) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) s_d = s_nxt;
      if (tick && s_nxt == OS_W'(OS_H - 1)) smp_d[0] = rxs_q;
      if (tick && s_nxt == OS_W'(OS_H))     smp_d[1] = rxs_q;
    end

    case (state_q)
      S_IDLE: begin
        if (rxs_dly_q && !rxs_q) begin
          state_d = S_START;
          div_d   = '0;
          s_d     = '0;
        end
      end
      S_START: begin
        if (decide && maj) begin
          state_d = S_IDLE;
        end else if (wrap) begin
          state_d = S_DATA;
          bit_d   = '0;
          perr_d  = 1'b0;
        end
      end
      S_DATA: begin
        if (decide) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
        if (wrap) begin
          if (bit_q == BIT_W'(DATA_BITS - 1)) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          else                                 bit_d   = bit_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (decide) perr_d = (^shreg_q) ^ maj ^ 1'(PARITY_ODD);
        if (wrap)   state_d = S_STOP;
      end
      S_STOP: begin
        // Decided mid-bit so a back-to-back start edge is seen from IDLE.
        if (decide) begin
          data_d     = shreg_q;
          perr_pls_d = perr_q;
          if (maj) begin
            valid_d = !perr_q;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_dly_q  <= 1'b1;
      div_q      <= '0;
      s_q        <= '0;
      bit_q      <= '0;
      smp_q      <= '0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_pls_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      rxs_q      <= rxs_d;
      rxs_dly_q  <= rxs_dly_d;
      div_q      <= div_d;
      s_q        <= s_d;
      bit_q      <= bit_d;
      smp_q      <= smp_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_pls_q <= perr_pls_d;
    end
  end

  assign rx_data_out       = data_q;
  assign rx_valid_out      = valid_q;
  assign rx_busy_out       = (state_q != S_IDLE);
  assign rx_frame_err_out  = ferr_q;
  assign rx_parity_err_out = perr_pls_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 receiver and an 8E1 receiver driven by bit-level serial frames.
// Pulses are logged at the falling clock edge and compared against expectations derived from the frame.
module tb_uart_rx_os;

  localparam int BIT   = 32;
  localparam int LAT_N = (1 + 8) * 8 * 4 + 5 * 4 + 3;
  localparam int LAT_P = (1 + 8 + 1) * 8 * 4 + 5 * 4 + 3;

  typedef struct {
    int         cyc;
    logic       v;
    logic       f;
    logic       p;
    logic [7:0] d;
  } evt_t;

  logic       clk;
  logic       nrst;
  logic       rx_a, rx_p;
  logic [7:0] data_a, data_p;
  logic       valid_a, busy_a, ferr_a, perr_a;
  logic       valid_p, busy_p, ferr_p, perr_p;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  evt_t evq_a[$];
  evt_t evq_p[$];
  bit   fr[$];

  uart_rx_os dut_a (
    .sysclk_in(clk), .nrst_in(nrst), .rx_serial_in(rx_a),
    .rx_data_out(data_a), .rx_valid_out(valid_a), .rx_busy_out(busy_a),
    .rx_frame_err_out(ferr_a), .rx_parity_err_out(perr_a)
  );

  uart_rx_os #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .sysclk_in(clk), .nrst_in(nrst), .rx_serial_in(rx_p),
    .rx_data_out(data_p), .rx_valid_out(valid_p), .rx_busy_out(busy_p),
    .rx_frame_err_out(ferr_p), .rx_parity_err_out(perr_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    evt_t e;
    if (valid_a || ferr_a || perr_a) begin
      e.cyc = cyc; e.v = valid_a; e.f = ferr_a; e.p = perr_a; e.d = data_a;
      evq_a.push_back(e);
    end
    if (valid_p || ferr_p || perr_p) begin
      e.cyc = cyc; e.v = valid_p; e.f = ferr_p; e.p = perr_p; e.d = data_p;
      evq_p.push_back(e);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit v);
    if (sel) rx_p = v;
    else     rx_a = v;
  endtask

  // Appends one frame: start, data LSB first, optional parity, nstop stop-bit slots.
  task automatic build(input logic [7:0] d, input bit par_en, input bit pbit,
                       input int nstop, input bit stop_val);
    fr.push_back(1'b0);
    for (int i = 0; i < 8; i++) fr.push_back(d[i]);
    if (par_en) fr.push_back(pbit);
    for (int i = 0; i < nstop; i++) fr.push_back(stop_val);
  endtask

  // One-cycle inverted glitch at offset 16 of bit slot glitch_idx (mid-bit sample point).
  task automatic play(input bit sel, input int glitch_idx, output int t0);
    t0 = cyc;
    foreach (fr[i]) begin
      for (int j = 0; j < BIT; j++) begin
        drive(sel, (i == glitch_idx && j == 16) ? ~fr[i] : fr[i]);
        @(negedge clk);
      end
    end
    fr.delete();
  endtask

  task automatic expect_frame(input bit sel, input logic [7:0] d, input bit v, input bit f,
                              input bit p, input int t0, input int lat);
    evt_t e;
    int   n;
    n = sel ? evq_p.size() : evq_a.size();
    chk("pulse_present", int'(n > 0), 1);
    if (n == 0) return;
    e = sel ? evq_p.pop_front() : evq_a.pop_front();
    chk("data", e.d, d);
    chk("valid", e.v, v);
    chk("frame_err", e.f, f);
    chk("parity_err", e.p, p);
    chk("latency_window", int'((e.cyc - t0) >= lat - 2 && (e.cyc - t0) <= lat + 2), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int         t0, t1;
    logic [7:0] d;
    bit         pb, exp_perr;

    nrst = 1'b0;
    rx_a = 1'b1;
    rx_p = 1'b1;
    idle(3);
    chk("rst_data", data_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_ferr", ferr_a, 0);
    chk("rst_perr", perr_p, 0);
    nrst = 1'b1;
    idle(10);

    // Basic 8N1 frame.
    build(8'hA5, 0, 0, 1, 1);
    play(0, -1, t0);
    expect_frame(0, 8'hA5, 1, 0, 0, t0, LAT_N);
    chk("a5_busy_after", busy_a, 0);
    chk("a5_single_pulse", evq_a.size(), 0);
    idle(20);

    // Short low pulse is rejected as a false start.
    rx_a = 1'b0;
    idle(5);
    chk("false_start_busy", busy_a, 1);
    idle(3);
    rx_a = 1'b1;
    idle(20);
    chk("false_start_idle", busy_a, 0);
    chk("false_start_no_pulse", evq_a.size(), 0);
    idle(40);

    // Stop bit held low for two bit times.
    build(8'h3C, 0, 0, 2, 0);
    play(0, -1, t0);
    expect_frame(0, 8'h3C, 0, 1, 0, t0, LAT_N);
    chk("break_busy", busy_a, 1);
    rx_a = 1'b1;
    idle(6);
    chk("break_released", busy_a, 0);
    chk("break_data_held", data_a, 8'h3C);
    chk("break_single_pulse", evq_a.size(), 0);
    idle(20);

    // Even parity: 0x07 has three ones, so parity bit 0 is wrong and 1 is right.
    build(8'h07, 1, 0, 1, 1);
    play(1, -1, t0);
    expect_frame(1, 8'h07, 0, 0, 1, t0, LAT_P);
    idle(20);
    build(8'h07, 1, 1, 1, 1);
    play(1, -1, t0);
    expect_frame(1, 8'h07, 1, 0, 0, t0, LAT_P);
    chk("par_single_pulse", evq_p.size(), 0);
    idle(20);

    // Back-to-back frames, glitch in data bit 3 of the first.
    build(8'h00, 0, 0, 1, 1);
    build(8'hFF, 0, 0, 1, 1);
    play(0, 4, t0);
    t1 = t0 + 10 * BIT;
    expect_frame(0, 8'h00, 1, 0, 0, t0, LAT_N);
    expect_frame(0, 8'hFF, 1, 0, 0, t1, LAT_N);
    chk("b2b_pulse_count", evq_a.size(), 0);
    idle(20);

    // Reset during data bit 4 of 0x55; the transmitter abandons the frame.
    build(8'h55, 0, 0, 1, 1);
    fr = fr[0:4];
    play(0, -1, t0);
    rx_a = 1'b1;
    idle(16);
    nrst = 1'b0;
    idle(1);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_data", data_a, 0);
    idle(3);
    nrst = 1'b1;
    idle(2 * BIT);
    chk("midrst_no_pulse", evq_a.size(), 0);
    chk("midrst_idle", busy_a, 0);
    build(8'h81, 0, 0, 1, 1);
    play(0, -1, t0);
    expect_frame(0, 8'h81, 1, 0, 0, t0, LAT_N);
    idle(20);

    // Random 8N1 traffic with random idle gaps.
    for (int k = 0; k < 16; k++) begin
      d = 8'($urandom);
      build(d, 0, 0, 1, 1);
      play(0, -1, t0);
      expect_frame(0, d, 1, 0, 0, t0, LAT_N);
      idle($urandom_range(0, 40));
    end
    chk("rand_a_no_extra", evq_a.size(), 0);

    // Random 8E1 traffic with a random parity bit; error iff total ones is odd.
    for (int k = 0; k < 16; k++) begin
      d        = 8'($urandom);
      pb       = 1'($urandom);
      exp_perr = (($countones(d) + int'(pb)) % 2) != 0;
      build(d, 1, pb, 1, 1);
      play(1, -1, t0);
      expect_frame(1, d, !exp_perr, 0, exp_perr, t0, LAT_P);
      idle($urandom_range(0, 40));
    end
    chk("rand_p_no_extra", evq_p.size(), 0);
    chk("final_idle_a", busy_a, 0);
    chk("final_idle_p", busy_p, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
